// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM write/read feeder blocks.
package sdram_pkg;
    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 20;
    localparam int DEF_BURST_LEN = 256;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } wr_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy output and sync clear.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             pop,
    output logic [AW:0]      level
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push;

    assign empty = (level == '0);
    assign full  = (level == DEPTH);
    assign pop   = rd_en && !empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign push  = wr_en && (!full || pop);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sdram_wr_buffer.sv
// Buffers the capture word stream and hands it to the SDRAM controller in full bursts.
module sdram_wr_buffer
    import sdram_pkg::*;
#(
    parameter int                FIFO_AW   = 9,
    parameter int                BURST_LEN = DEF_BURST_LEN,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 20'h00000,
    parameter logic [ADDR_W-1:0] ADDR_LAST = 20'hFFFFF
) (
    input  logic              S_CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              frame_start,
    output logic [DATA_W-1:0] sdram_data,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              fifo_rd_req,
    output logic              write_req,
    input  logic              write_ack,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              ovf_err,
    output logic              unf_err
);
    localparam int               CW        = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(BURST_LEN - 1);
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW + 1)'(BURST_LEN);

    wr_state_t     state, nxt;
    logic [CW-1:0] cnt;
    logic          pend, clr, leave, full, empty, pop;

    sync_fifo_fwft #(.WIDTH(DATA_W), .AW(FIFO_AW)) u_fifo (
        .clk   (S_CLK),
        .rst   (RST),
        .clr   (clr),
        .wr_en (din_valid && !pend),
        .din   (din),
        .rd_en (fifo_rd_req),
        .dout  (sdram_data),
        .full  (full),
        .empty (empty),
        .pop   (pop),
        .level (fifo_level)
    );

    assign din_ready = !full && !pend;
    assign write_req = (state == REQ);
    // A frame restart mid-burst waits for the burst to close so it is never torn.
    assign clr = (frame_start && state == IDLE) || (leave && (pend || frame_start));

    always_comb begin
        nxt   = state;
        leave = 1'b0;
        case (state)
            IDLE:     if (!frame_start && fifo_level >= BURST_LVL && !write_ack) nxt = REQ;
            REQ:      if (pop && cnt == CNT_LAST) nxt = WAIT_ACK;
            WAIT_ACK: if (write_ack) begin
                          nxt   = IDLE;
                          leave = 1'b1;
                      end
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= 1'b0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            sdram_addr <= ADDR_BASE;
        end else begin
            state <= nxt;
            if (state == IDLE)      cnt <= '0;
            else if (state == REQ && pop) cnt <= cnt + 1'b1;
            if (clr) begin
                pend       <= 1'b0;
                ovf_err    <= 1'b0;
                unf_err    <= 1'b0;
                sdram_addr <= ADDR_BASE;
            end else begin
                if (frame_start && state != IDLE)           pend    <= 1'b1;
                if (din_valid && full && !pop && !pend)     ovf_err <= 1'b1;
                if (fifo_rd_req && empty)                   unf_err <= 1'b1;
                if (pop) sdram_addr <= (sdram_addr == ADDR_LAST) ? ADDR_BASE : sdram_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Scoreboard bench for sdram_wr_buffer: bursts, address wrap, refresh preemption, errors, frame restart.
module tb_sdram_wr_buffer;
    localparam logic [19:0] BASE = 20'h00100;
    localparam logic [19:0] LAST = 20'h001FF;

    logic        S_CLK = 1'b0;
    logic        RST   = 1'b0;
    logic [15:0] din;
    logic        din_valid, din_ready, frame_start, fifo_rd_req, write_req, write_ack;
    logic [15:0] sdram_data;
    logic [19:0] sdram_addr;
    logic [9:0]  fifo_level;
    logic        ovf_err, unf_err;

    always #5 S_CLK = ~S_CLK;

    sdram_wr_buffer #(.FIFO_AW(9), .BURST_LEN(256), .ADDR_BASE(BASE), .ADDR_LAST(LAST)) dut (
        .S_CLK(S_CLK), .RST(RST), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .frame_start(frame_start), .sdram_data(sdram_data), .sdram_addr(sdram_addr),
        .fifo_rd_req(fifo_rd_req), .write_req(write_req), .write_ack(write_ack),
        .fifo_level(fifo_level), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    int          checks = 0, errors = 0;
    logic [15:0] q[$];
    logic [19:0] exp_addr;
    bit          pend_m, exp_ovf, exp_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_CLK);
        #1;
    endtask

    task automatic do_push(input logic [15:0] w);
        din = w; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        if (!pend_m && q.size() < 512) q.push_back(w);
        else if (!pend_m) exp_ovf = 1'b1;
    endtask

    task automatic do_pop();
        chk("data", 32'(sdram_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        chk("addr", 32'(sdram_addr), 32'(exp_addr));
        fifo_rd_req = 1'b1;
        tick();
        fifo_rd_req = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            exp_addr = (exp_addr == LAST) ? BASE : exp_addr + 20'd1;
        end else exp_unf = 1'b1;
    endtask

    // Pops one full burst; ack_at >= 0 inserts a refresh ack before that pop.
    task automatic pop_burst(input int ack_at);
        for (int i = 0; i < 256; i++) begin
            if (i == ack_at) begin
                write_ack = 1'b1; tick(); write_ack = 1'b0;
                chk("refresh_hold", 32'(write_req), 32'h1);
            end
            do_pop();
            chk("req_during_burst", 32'(write_req), (i < 255) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic ack_burst();
        write_ack = 1'b1; tick(); write_ack = 1'b0;
        if (pend_m) begin
            q.delete(); exp_addr = BASE; pend_m = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        end
    endtask

    initial begin
        din = '0; din_valid = 0; frame_start = 0; fifo_rd_req = 0; write_ack = 0;
        exp_addr = BASE; pend_m = 0; exp_ovf = 0; exp_unf = 0;
        #1 RST = 1'b1;
        #1;
        chk("rst_req",   32'(write_req),  32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_addr",  32'(sdram_addr), 32'(BASE));
        chk("rst_data",  32'(sdram_data), 32'h0);
        chk("rst_ovf",   32'(ovf_err),    32'h0);
        chk("rst_unf",   32'(unf_err),    32'h0);
        #21 RST = 1'b0;
        tick();
        chk("rst_ready", 32'(din_ready), 32'h1);

        // partial burst never requested, the 256th word triggers one cycle later
        for (int i = 0; i < 255; i++) do_push(16'(i));
        repeat (20) tick();
        chk("partial_noreq", 32'(write_req),  32'h0);
        chk("partial_level", 32'(fifo_level), 32'd255);
        do_push(16'h00FF);
        chk("req_latency", 32'(write_req), 32'h0);
        tick();
        chk("req_rise", 32'(write_req), 32'h1);
        pop_burst(-1);
        chk("burst1_level", 32'(fifo_level), 32'(q.size()));
        ack_burst(); tick();

        // second burst wraps the window and is preempted by a refresh after 100 pops
        for (int i = 0; i < 256; i++) do_push(16'h1000 + 16'(i));
        tick();
        chk("burst2_req", 32'(write_req), 32'h1);
        pop_burst(100);
        ack_burst(); tick();

        // overflow at full, frame restart held off until the burst closes
        for (int i = 0; i < 512; i++) do_push(16'h2000 + 16'(i));
        chk("full_level", 32'(fifo_level), 32'd512);
        chk("full_ready", 32'(din_ready),  32'h0);
        do_push(16'hDEAD);
        chk("ovf_set",   32'(ovf_err),    32'(exp_ovf));
        chk("ovf_level", 32'(fifo_level), 32'd512);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pend_m = 1'b1;
        chk("pend_req", 32'(write_req), 32'h1);
        pop_burst(-1);
        chk("pend_level", 32'(fifo_level), 32'd256);
        chk("pend_ready", 32'(din_ready),  32'h0);
        do_push(16'hBEEF);
        chk("pend_drop", 32'(fifo_level), 32'(q.size()));
        ack_burst();
        chk("clr_level", 32'(fifo_level), 32'(q.size()));
        chk("clr_addr",  32'(sdram_addr), 32'(exp_addr));
        chk("clr_ovf",   32'(ovf_err),    32'(exp_ovf));
        chk("clr_ready", 32'(din_ready),  32'h1);
        chk("clr_data",  32'(sdram_data), 32'h0);

        // underflow, then frame restart from IDLE
        do_pop();
        chk("unf_set",  32'(unf_err),    32'(exp_unf));
        chk("unf_addr", 32'(sdram_addr), 32'(exp_addr));
        for (int i = 0; i < 10; i++) do_push(16'h3000 + 16'(i));
        chk("idle_level", 32'(fifo_level), 32'd10);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        q.delete(); exp_addr = BASE; exp_unf = 1'b0;
        chk("fs_unf",   32'(unf_err),    32'(exp_unf));
        chk("fs_level", 32'(fifo_level), 32'h0);
        chk("fs_addr",  32'(sdram_addr), 32'(exp_addr));
        chk("fs_req",   32'(write_req),  32'h0);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 256; i++) do_push(16'h4000 + 16'(i));
        tick();
        chk("b4_req", 32'(write_req), 32'h1);
        for (int i = 0; i < 5; i++) do_pop();
        #2 RST = 1'b1;
        #1;
        chk("midrst_req",   32'(write_req),  32'h0);
        chk("midrst_level", 32'(fifo_level), 32'h0);
        chk("midrst_addr",  32'(sdram_addr), 32'(BASE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_wr_buffer.md
Name: sdram_wr_buffer

Overview:
- Upstream feeder for the SDRAM write path: accepts a 16-bit word stream from the capture/user side and buffers it in an internal synchronous FIFO.
- Drives the controller's write side: `sdram_data`, `sdram_addr` and `write_req`. It consumes `fifo_rd_req` pops and watches `write_ack`.
- Issues one `write_req` per full burst of BURST_LEN words, with a linearly advancing 20-bit word address that wraps inside a programmable window.

Parameters:
- FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW words.
- BURST_LEN, 256, words per write request; must be ≤ 2^FIFO_AW and a power of two.
- ADDR_BASE, 20'h00000, first word address of the write window.
- ADDR_LAST, 20'hFFFFF, last word address of the window; wrap point.

Ports:
- S_CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- din  in  16  input data word.
- din_valid  in  1  `din` is written to the FIFO this cycle if not full.
- din_ready  out  1  FIFO not full.
- frame_start  in  1  single-cycle pulse; restarts the address and clears the FIFO.
- sdram_data  out  16  FIFO head word (first-word-fall-through).
- sdram_addr  out  20  word address of the current head word.
- fifo_rd_req  in  1  controller pop strobe; one word per asserted cycle.
- write_req  out  1  burst request to the controller.
- write_ack  in  1  controller end-of-burst acknowledge.
- fifo_level  out  FIFO_AW+1  current occupancy.
- ovf_err  out  1  sticky: `din_valid` asserted while full.
- unf_err  out  1  sticky: `fifo_rd_req` asserted while empty.

Behaviour:
- Reset (RST high, asynchronous): FIFO empty, `fifo_level`=0, `write_req`=0, `sdram_addr`=ADDR_BASE, `sdram_data`=0, `ovf_err`=`unf_err`=0, pop counter=0, state IDLE. `din_ready`=1 once RST is low.
- Reset mid-burst: `write_req` drops immediately with RST. Buffered data is discarded.
- FIFO write: when `din_valid`=1 and `din_ready`=1, `din` is stored at the rising edge.
- FIFO read: `sdram_data` shows the head word combinationally from the register file; it shows 0 when empty. `fifo_rd_req`=1 with the FIFO not empty pops at the edge, so the next word is visible the following cycle.
- Simultaneous push and pop: level unchanged. Push succeeds even when full if a pop occurs in the same cycle.
- Errors: push when full without a pop is dropped and sets `ovf_err`. Pop when empty is ignored and sets `unf_err`. Both flags clear only on RST or `frame_start`.
- Address: `sdram_addr` increments by 1 per successful pop. After ADDR_LAST the next value is ADDR_BASE. Arithmetic is 20-bit unsigned.
- State machine:
  - IDLE → REQ when `fifo_level` ≥ BURST_LEN and `write_ack`=0. Set `write_req`=1 (registered) and clear the pop counter.
  - REQ: count successful pops. When the count reaches BURST_LEN, deassert `write_req` and go to WAIT_ACK. Extra pops beyond BURST_LEN in REQ are impossible because `write_req` is deasserted on the same edge.
  - WAIT_ACK: hold `write_req`=0. Return to IDLE on the first cycle with `write_ack`=1, or the same cycle if the ack is already high.
- Controller refresh preemption (controller stops popping, then acks): if `write_ack`=1 in REQ before BURST_LEN pops, keep `write_req`=1 and stay in REQ. The controller re-enters WRITE and pops resume; the address continues seamlessly.
- `frame_start`: synchronous. In IDLE it clears the FIFO, error flags and address immediately. In REQ or WAIT_ACK it is latched as pending and applied on the transition back to IDLE, so a burst is never torn. `din` writes are blocked (`din_ready`=0) while the pending flag is set.
- Partial bursts: fewer than BURST_LEN words are never requested; they remain buffered.

Decomposition:
- Shared package `sdram_pkg`: state encoding (IDLE/REQ/WAIT_ACK), SDRAM word-address width (20), data width (16), default BURST_LEN.
- One sub-module: `sync_fifo_fwft` (parameterised width/depth, FWFT read, level output, full/empty). It is reused later by the read path.

Test Plan:
- Reset, then push 256 words 0x0000..0x00FF → `write_req` rises 1 cycle after level reaches 256. Pop 256 cycles: `sdram_data` equals 0x0000..0x00FF and `sdram_addr` runs 0x00000..0x000FF. `write_req` falls on the 256th pop. `write_ack` returns the state to IDLE.
- Push 255 words → `write_req` stays 0 indefinitely. Push the 256th → request issued.
- ADDR_BASE=0x00100, ADDR_LAST=0x001FF, two bursts → second burst addresses are 0x00100..0x001FF again (wrap).
- Mid-burst: pop 100 words, pulse `write_ack` (refresh), resume pops → `write_req` stays 1, `sdram_addr` continues from 0x00064, and the burst completes at 256 pops.
- Fill to 512 and push once more without a pop → `ovf_err`=1 and `fifo_level`=512. Pop when empty → `unf_err`=1. `frame_start` in IDLE clears both flags and sets level to 0.
- `frame_start` during REQ → the burst finishes normally. After `write_ack`, FIFO is cleared and `sdram_addr`=ADDR_BASE. `din_ready`=0 until then.
